// File: rtl/uart_rx_param_pkg.sv
// Shared types, constants and helpers for the parametrised UART receiver.
package uart_rx_param_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // 2-of-3 majority.
    function automatic logic maj3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning: 2-flop synchroniser plus 3-tap majority filter on oversample ticks.
module uart_rx_sampler
    import uart_rx_param_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clken_os,
    input  logic rxd,
    output logic rxd_s,
    output logic vote
);

    logic       sync1;
    logic [2:0] hist;

    // Synchroniser runs every clock; resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    // History shifts on ticks; vote is registered alongside so it always equals maj3(hist).
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 3'b111;
            vote <= 1'b1;
        end else if (clken_os) begin
            hist <= {hist[1:0], rxd_s};
            vote <= maj3({hist[1:0], rxd_s});
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data/parity/stop format, majority sampling, error and break handling.
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clken_os,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rxd_data,
    output logic                 rxd_flag,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned   CW        = clog2(OVERSAMPLE);
    localparam logic [CW-1:0] D_PT      = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_PT      = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic rxd_s;
    logic vote;

    state_t               state_q, state_d;
    logic [CW-1:0]        smp_q, smp_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 flag_d, pe_d, fe_d, busy_d;
    logic                 at_d, at_t;

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
        .clken_os (clken_os),
        .rxd      (rxd),
        .rxd_s    (rxd_s),
        .vote     (vote)
    );

    assign at_d = clken_os && (smp_q == D_PT);
    assign at_t = clken_os && (smp_q == T_PT);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            smp_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rxd_data   <= '0;
            rxd_flag   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_q      <= smp_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            rxd_data   <= data_d;
            rxd_flag   <= flag_d;
            parity_err <= pe_d;
            frame_err  <= fe_d;
            busy       <= busy_d;
        end
    end

    // Frame sequencing: next state, counters, sample capture and flag generation.
    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        data_d  = rxd_data;
        flag_d  = 1'b0;
        pe_d    = 1'b0;
        fe_d    = 1'b0;

        if (clken_os && state_q != S_IDLE && state_q != S_BREAK) begin
            smp_d = at_t ? '0 : smp_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                // A tick coinciding with the start edge is dropped: count restarts at 0.
                smp_d  = '0;
                bit_d  = '0;
                stop_d = 1'b0;
                if (!rxd_s) begin
                    state_d = S_START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (at_d && vote) begin
                    state_d = S_IDLE;
                    smp_d   = '0;
                end else if (at_t) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_d) begin
                    for (int i = 0; i < int'(DATA_BITS); i++) begin
                        if (bit_q == 4'(i)) shift_d[i] = vote;
                    end
                end
                if (at_t) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_d) perr_d = vote ^ (^shift_q) ^ PAR_SENSE;
                if (at_t) state_d = S_STOP;
            end
            S_STOP: begin
                if (at_d) begin
                    ferr_d = ferr_q | ~vote;
                    // Final stop bit completes at mid-bit so the next start edge is not missed.
                    if (stop_q == LAST_STOP) begin
                        data_d  = shift_q;
                        flag_d  = 1'b1;
                        pe_d    = perr_q;
                        fe_d    = ferr_q | ~vote;
                        state_d = vote ? S_IDLE : S_BREAK;
                    end
                end
                if (at_t) stop_d = stop_q + 1'b1;
            end
            S_BREAK: begin
                smp_d = '0;
                if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: three receiver configurations against a frame-level expectation model.
module tb_uart_rx_param;

    localparam int OS = 16;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         t_lo;
        int         t_hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clken_os;
    logic rxd_a, rxd_b, rxd_c;

    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic flag_a, flag_b, flag_c;
    logic pe_a, pe_b, pe_c;
    logic fe_a, fe_b, fe_c;
    logic busy_a, busy_b, busy_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int flag_cnt [3];
    logic last_pe [3];
    logic last_fe [3];

    exp_t q_a [$];
    exp_t q_b [$];
    exp_t q_c [$];

    // 8N1
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .clken_os(clken_os), .rxd(rxd_a),
        .rxd_data(data_a), .rxd_flag(flag_a), .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a));

    // 7E1
    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .clken_os(clken_os), .rxd(rxd_b),
        .rxd_data(data_b), .rxd_flag(flag_b), .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b));

    // 8N2
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .clken_os(clken_os), .rxd(rxd_c),
        .rxd_data(data_c), .rxd_flag(flag_c), .parity_err(pe_c), .frame_err(fe_c), .busy(busy_c));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oversample tick every second clock.
    initial begin
        clken_os = 1'b0;
        forever begin
            @(posedge clk);
            #1 clken_os = ~clken_os;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rxd(input int inst, input logic v);
        case (inst)
            0: rxd_a = v;
            1: rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic push_exp(input int inst, input exp_t e);
        case (inst)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    // One bit time; optional single-tick inversion at tick g.
    task automatic drive_bit(input int inst, input logic v, input int g);
        for (int t = 0; t < OS; t++) begin
            set_rxd(inst, (t == g) ? ~v : v);
            tick_wait(2);
        end
    endtask

    task automatic idle(input int inst, input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(inst, 1'b1, -1);
    endtask

    // Drives a whole frame and records what the receiver must report for it.
    task automatic send_frame(input int inst, input logic [8:0] d, input int nbits,
                              input bit has_par, input logic par_bit,
                              input int nstop, input logic stop_v, input int glitch_bit);
        exp_t e;
        logic x;
        x = 1'b0;
        e.data = '0;
        for (int i = 0; i < nbits; i++) begin
            e.data[i] = d[i];
            x = x ^ d[i];
        end
        e.perr = has_par ? (par_bit != x) : 1'b0;
        e.ferr = ~stop_v;
        drive_bit(inst, 1'b0, -1);
        for (int i = 0; i < nbits; i++) drive_bit(inst, d[i], (i == glitch_bit) ? 7 : -1);
        if (has_par) drive_bit(inst, par_bit, -1);
        for (int s = 0; s < nstop; s++) begin
            if (s == nstop - 1) begin
                e.t_lo = cyc;
                e.t_hi = cyc + 2 * OS + 4;
                push_exp(inst, e);
            end
            drive_bit(inst, stop_v, -1);
        end
    endtask

    task automatic check_flag(input int inst, input logic f, input logic [8:0] d,
                              input logic pe, input logic fe);
        exp_t e;
        bit have;
        if (f !== 1'b1) begin
            chk("err_without_flag", 32'({f, pe, fe}), 32'd0);
            return;
        end
        have = 1'b0;
        case (inst)
            0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
            1: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
        endcase
        flag_cnt[inst]++;
        last_pe[inst] = pe;
        last_fe[inst] = fe;
        total++;
        if (!have) begin
            bad++;
            $display("FAIL unexpected_flag inst=%0d: got data %0h, want no flag (cycle %0d)", inst, d, cyc);
            return;
        end
        chk("flag_data", 32'(d), 32'(e.data));
        chk("flag_parity_err", 32'(pe), 32'(e.perr));
        chk("flag_frame_err", 32'(fe), 32'(e.ferr));
        chk("flag_time_in_stop_bit", 32'(cyc >= e.t_lo && cyc <= e.t_hi), 32'd1);
    endtask

    // Per-cycle comparison against the frame model.
    always @(negedge clk) begin
        check_flag(0, flag_a, {1'b0, data_a}, pe_a, fe_a);
        check_flag(1, flag_b, {2'b0, data_b}, pe_b, fe_b);
        check_flag(2, flag_c, {1'b0, data_c}, pe_c, fe_c);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            flag_cnt[i] = 0;
            last_pe[i]  = 1'b0;
            last_fe[i]  = 1'b0;
        end
        rst   = 1'b1;
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        rxd_c = 1'b1;
        tick_wait(4);

        chk("rst_data_a", 32'(data_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_data_b", 32'(data_b), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_data_c", 32'(data_c), 32'd0);
        chk("rst_busy_c", 32'(busy_c), 32'd0);

        rst = 1'b0;
        tick_wait(8);

        // 8N1 0xA5
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(0, 2);
        chk("a5_data", 32'(data_a), 32'h0A5);
        chk("a5_flags", 32'(flag_cnt[0]), 32'd1);
        chk("a5_perr", 32'(last_pe[0]), 32'd0);
        chk("a5_ferr", 32'(last_fe[0]), 32'd0);
        chk("a5_busy_after", 32'(busy_a), 32'd0);

        // 7E1 0x55, wrong then correct parity
        send_frame(1, 9'h055, 7, 1'b1, 1'b1, 1, 1'b1, -1);
        idle(1, 2);
        chk("e7_bad_data", 32'(data_b), 32'h055);
        chk("e7_bad_perr", 32'(last_pe[1]), 32'd1);
        send_frame(1, 9'h055, 7, 1'b1, 1'b0, 1, 1'b1, -1);
        idle(1, 2);
        chk("e7_good_perr", 32'(last_pe[1]), 32'd0);
        chk("e7_flags", 32'(flag_cnt[1]), 32'd2);

        // False start: 3-tick low glitch
        set_rxd(0, 1'b0);
        tick_wait(6);
        set_rxd(0, 1'b1);
        tick_wait(1);
        chk("glitch_busy_in_start", 32'(busy_a), 32'd1);
        idle(0, 2);
        chk("glitch_busy_after", 32'(busy_a), 32'd0);
        chk("glitch_no_flag", 32'(flag_cnt[0]), 32'd1);
        chk("glitch_data_held", 32'(data_a), 32'h0A5);

        // Mid-bit single-tick glitch in data bit 3 of 0x00
        send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b1, 3);
        idle(0, 2);
        chk("vote_data", 32'(data_a), 32'h000);
        chk("vote_flags", 32'(flag_cnt[0]), 32'd2);

        // Framing error into break, then a clean frame
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b0, -1);
        drive_bit(0, 1'b0, -1);
        drive_bit(0, 1'b0, -1);
        chk("brk_ferr", 32'(last_fe[0]), 32'd1);
        chk("brk_data", 32'(data_a), 32'h081);
        chk("brk_busy_held", 32'(busy_a), 32'd1);
        idle(0, 2);
        chk("brk_busy_released", 32'(busy_a), 32'd0);
        chk("brk_single_flag", 32'(flag_cnt[0]), 32'd3);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(0, 2);
        chk("post_brk_data", 32'(data_a), 32'h03C);
        chk("post_brk_ferr", 32'(last_fe[0]), 32'd0);
        chk("post_brk_flags", 32'(flag_cnt[0]), 32'd4);

        // 8N2 back-to-back
        send_frame(2, 9'h012, 8, 1'b0, 1'b0, 2, 1'b1, -1);
        send_frame(2, 9'h034, 8, 1'b0, 1'b0, 2, 1'b1, -1);
        idle(2, 2);
        chk("b2b_flags", 32'(flag_cnt[2]), 32'd2);
        chk("b2b_data", 32'(data_c), 32'h034);

        // Reset mid second frame of a back-to-back pair
        send_frame(2, 9'h056, 8, 1'b0, 1'b0, 2, 1'b1, -1);
        drive_bit(2, 1'b0, -1);
        drive_bit(2, 1'b0, -1);
        drive_bit(2, 1'b0, -1);
        drive_bit(2, 1'b0, -1);
        chk("pre_rst_busy", 32'(busy_c), 32'd1);
        chk("pre_rst_data", 32'(data_c), 32'h056);
        rst = 1'b1;
        set_rxd(2, 1'b1);
        tick_wait(2);
        chk("rst_mid_data", 32'(data_c), 32'd0);
        chk("rst_mid_flag", 32'(flag_c), 32'd0);
        chk("rst_mid_errs", 32'({pe_c, fe_c}), 32'd0);
        chk("rst_mid_busy", 32'(busy_c), 32'd0);
        rst = 1'b0;
        idle(2, 3);
        chk("rst_mid_no_flag", 32'(flag_cnt[2]), 32'd3);
        chk("rst_mid_idle", 32'(busy_c), 32'd0);

        chk("pending_a", 32'(q_a.size()), 32'd0);
        chk("pending_b", 32'(q_b.size()), 32'd0);
        chk("pending_c", 32'(q_c.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
